fifo_word_packer: RTL
=====================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8, width of one byte read from the async FIFO read port.
REQ-002 Parameter PACK_RATIO, default 4, bytes per output word; legal values 2..8.
REQ-003 read_clk  input  1  sole clock; the same read clock as the upstream async FIFO.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_data  input  IN_WIDTH  FIFO data_out; valid the cycle after a read_enable pop.
REQ-007 read_enable  output  1  pop request to the FIFO.
REQ-008 word_data  output  IN_WIDTH*PACK_RATIO  packed word; first byte in bits [IN_WIDTH-1:0].
REQ-009 word_keep  output  PACK_RATIO  per-byte valid mask, contiguous from bit 0.
REQ-010 word_valid  output  1  word_data/word_keep hold a word.
REQ-011 word_ready  input  1  consumer accepts; transfer = word_valid && word_ready.
REQ-012 flush  input  1  single-cycle request to emit any partial word.
REQ-013 flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-014 Pop rule: read_enable = !fifo_empty && state==ACTIVE && !flush && (count_eff + pending) < PACK_RATIO, where count_eff is the assembly count after removing any word leaving assembly on this edge.
REQ-015 pending is set on the edge a pop issues; fifo_data is captured into assembly slot [count] on the following edge, and pending clears.
REQ-016 Full word: on the edge where count==PACK_RATIO and the output register is empty or transferring, the word moves to output with word_keep all ones; count returns to 0.
REQ-017 Output register holds its contents stable while word_valid && !word_ready; it is never overwritten before transfer.
REQ-018 Sustained throughput, fifo never empty and word_ready high: PACK_RATIO bytes every PACK_RATIO+1 cycles.
REQ-019 Latency: first word_valid asserts PACK_RATIO+1 edges after the edge that samples the first read_enable.
REQ-020 State ACTIVE: normal fill; flush sampled high moves to FLUSHING.
REQ-021 State FLUSHING: no pops; wait until pending==0, then on the first edge the output register is empty or transferring: if count>0 move the partial word (unused bytes zero, word_keep = (1<<count)-1), then pulse flush_done and return to ACTIVE.
REQ-022 Flush with count==0 and pending==0: flush_done pulses on the next edge and no word is emitted.
REQ-023 Flush raised while FLUSHING is ignored; flush on the same edge a full word leaves assembly flushes only the remaining bytes.
REQ-024 fifo_empty rising with pending==1: the in-flight byte is still captured; no further pops.

Reset
REQ-025 reset_n low: state=ACTIVE, count=0, pending=0, assembly=0, word_data=0, word_keep=0, word_valid=0, read_enable=0, flush_done=0, asynchronously.
REQ-026 Reset mid-operation discards the in-flight byte and any partial or unaccepted word; no flush_done is issued.
REQ-027 First pop may issue no earlier than the first edge after reset_n deasserts.

Structure
REQ-028 The shared package holds the state enum (ACTIVE, FLUSHING) and the default IN_WIDTH/PACK_RATIO constants.
REQ-029 The output holding register with valid/ready is one sub-module, word_out_reg; counters and FSM stay in the top.

Verification
REQ-030 Bytes 0x11,0x22,0x33,0x44 preloaded, word_ready=1 -> word_data=0x44332211, keep=4'b1111, valid 5 edges after first pop.
REQ-031 Three bytes 0xA1,0xA2,0xA3, then flush -> word_data=0x00A3A2A1, keep=4'b0111, then flush_done pulses once.
REQ-032 word_ready=0 with 12 bytes queued -> one word held stable, 4 bytes assembled, read_enable low; release -> 3 words in order, no loss or duplication.
REQ-033 Flush with empty assembly -> flush_done one cycle later, word_valid stays 0.
REQ-034 reset_n low while pending==1 and count==2 -> all outputs 0 next cycle; subsequent bytes pack from slot 0.
REQ-035 Random fifo_empty/word_ready over 1000 bytes -> output byte stream equals input stream; read_enable never high while fifo_empty.

Source files
------------

// File: rtl/fifo_word_packer_pkg.sv
// Shared types and defaults for the FIFO byte-to-word packer.
package fifo_word_packer_pkg;

  localparam int DEF_IN_WIDTH   = 8;
  localparam int DEF_PACK_RATIO = 4;

  typedef enum logic {
    ACTIVE   = 1'b0,
    FLUSHING = 1'b1
  } state_e;

  // Contiguous byte-valid mask with the low n bits set; PACK_RATIO never exceeds 8.
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/fifo_word_packer_word_out_reg.sv
// Output holding register: one word with valid/ready, stable until accepted.
module word_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              read_clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              word_ready,
  output logic [DATA_W-1:0] word_data,
  output logic [KEEP_W-1:0] word_keep,
  output logic              word_valid,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;

  // The packer only asserts load when free is high, so a held word is never overwritten.
  always_comb begin
    free    = !valid_q || word_ready;
    valid_d = valid_q && !word_ready;
    data_d  = data_q;
    keep_d  = keep_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
    end
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign word_data  = data_q;
  assign word_keep  = keep_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from an async FIFO read port and packs PACK_RATIO of them per output word.
//   state    | meaning
//   ACTIVE   | popping and assembling bytes; full words go to the output register
//   FLUSHING | no pops; drain the in-flight byte, emit any partial word, pulse flush_done
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                           read_clk,
  input  logic                           reset_n,
  input  logic                           fifo_empty,
  input  logic [IN_WIDTH-1:0]            fifo_data,
  output logic                           read_enable,
  output logic [IN_WIDTH*PACK_RATIO-1:0] word_data,
  output logic [PACK_RATIO-1:0]          word_keep,
  output logic                           word_valid,
  input  logic                           word_ready,
  input  logic                           flush,
  output logic                           flush_done
);

  localparam int            CW       = $clog2(PACK_RATIO + 1);
  localparam int            WW       = IN_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] FULL_CNT = CW'(PACK_RATIO);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      count_q, count_d, count_eff;
  logic                               pending_q, pending_d;
  logic [PACK_RATIO-1:0][IN_WIDTH-1:0] asm_q, asm_d;
  logic                               flush_done_q, flush_done_d;
  logic                               out_free, move_full, flush_exit, move;
  logic [CW:0]                        fill;
  logic [7:0]                         keep_all;
  logic [PACK_RATIO-1:0]              load_keep;
  logic [WW-1:0]                      load_data;

  always_comb begin
    move_full  = (count_q == FULL_CNT) && out_free;
    flush_exit = (state_q == FLUSHING) && !pending_q && out_free;
    move       = move_full || (flush_exit && (count_q != '0));
    count_eff  = move ? '0 : count_q;

    // Bytes already owned (assembled plus in flight) must leave room for the next pop.
    fill        = {1'b0, count_eff} + {{CW{1'b0}}, pending_q};
    read_enable = reset_n && !fifo_empty && (state_q == ACTIVE) && !flush &&
                  (fill < {1'b0, FULL_CNT});
    pending_d   = read_enable;

    asm_d   = move ? '0 : asm_q;
    count_d = count_eff;
    if (pending_q) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (count_eff == CW'(i)) asm_d[i] = fifo_data;
      end
      count_d = count_eff + CW'(1);
    end

    keep_all  = keep_mask(4'(count_q));
    load_keep = keep_all[PACK_RATIO-1:0];
    load_data = asm_q;

    state_d = state_q;
    if ((state_q == ACTIVE) && flush) state_d = FLUSHING;
    else if (flush_exit)              state_d = ACTIVE;
    flush_done_d = flush_exit;
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ACTIVE;
      count_q      <= '0;
      pending_q    <= 1'b0;
      asm_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      asm_q        <= asm_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign flush_done = flush_done_q;

  word_out_reg #(
    .DATA_W(WW),
    .KEEP_W(PACK_RATIO)
  ) u_word_out_reg (
    .read_clk  (read_clk),
    .reset_n   (reset_n),
    .load      (move),
    .load_data (load_data),
    .load_keep (load_keep),
    .word_ready(word_ready),
    .word_data (word_data),
    .word_keep (word_keep),
    .word_valid(word_valid),
    .free      (out_free)
  );

endmodule
